// File: rtl/ddr3_rx_bitslip_align.sv
// Read-side word aligner for one DDR3 receive lane: slips the IOD until a training pattern locks.
// Optional macro DDR3_RX_ALIGN_OUT_REG_EN adds a second output register stage on the data path.
module ddr3_rx_bitslip_align #(
  parameter int unsigned           DATA_WIDTH    = 4,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 4'b0011,
  parameter int unsigned           SLIP_SETTLE   = 4,
  parameter int unsigned           MATCH_COUNT   = 16,
  parameter int unsigned           MAX_SLIPS     = 8
) (
  input  logic                  FAB_CLK,
  input  logic                  ARST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] RX_DATA_0,
  output logic                  RX_BIT_SLIP_0,
  output logic                  BUSY,
  output logic                  LOCKED,
  output logic                  FAIL,
  output logic [3:0]            SLIP_COUNT,
  output logic [DATA_WIDTH-1:0] RX_DATA_ALIGNED,
  output logic                  RX_VALID
);

  localparam logic [3:0] SettleLast = 4'(SLIP_SETTLE - 1);
  localparam logic [7:0] MatchLast  = 8'(MATCH_COUNT - 1);
  localparam logic [3:0] MaxSlips   = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {StIdle, StFlush, StCheck, StSlip, StLock, StFail} state_e;

  state_e     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] match_q, match_d;
  logic [3:0] slip_cnt_q, slip_cnt_d;
  logic       pattern_hit;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      match_q    <= '0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      match_q    <= match_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    match_d     = match_q;
    slip_cnt_d  = slip_cnt_q;
    pattern_hit = (RX_DATA_0 == TRAIN_PATTERN);
    unique case (state_q)
      StIdle, StLock, StFail: begin
        if (START) begin
          state_d    = StFlush;
          settle_d   = '0;
          match_d    = '0;
          slip_cnt_d = '0;
        end
      end
      StFlush: begin
        // Data right after a slip is unreliable; just let the IOD settle.
        settle_d = settle_q + 4'd1;
        if (settle_q == SettleLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (pattern_hit) begin
          match_d = match_q + 8'd1;
          if (match_q == MatchLast) begin
            state_d = StLock;
          end
        end else begin
          match_d = '0;
          state_d = (slip_cnt_q == MaxSlips) ? StFail : StSlip;
        end
      end
      StSlip: begin
        settle_d   = '0;
        slip_cnt_d = (slip_cnt_q == 4'hf) ? slip_cnt_q : slip_cnt_q + 4'd1;
        state_d    = StFlush;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    RX_BIT_SLIP_0 = (state_q == StSlip);
    BUSY          = (state_q == StFlush) || (state_q == StCheck) || (state_q == StSlip);
    LOCKED        = (state_q == StLock);
    FAIL          = (state_q == StFail);
    SLIP_COUNT    = slip_cnt_q;
  end

  logic [DATA_WIDTH-1:0] data_s1_q;
  logic                  valid_s1_q;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      data_s1_q  <= '0;
      valid_s1_q <= 1'b0;
    end else begin
      data_s1_q  <= RX_DATA_0;
      valid_s1_q <= (state_q == StLock);
    end
  end

`ifdef DDR3_RX_ALIGN_OUT_REG_EN
  logic [DATA_WIDTH-1:0] data_s2_q;
  logic                  valid_s2_q;

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      data_s2_q  <= '0;
      valid_s2_q <= 1'b0;
    end else begin
      data_s2_q  <= data_s1_q;
      valid_s2_q <= valid_s1_q;
    end
  end

  assign RX_DATA_ALIGNED = data_s2_q;
  assign RX_VALID        = valid_s2_q;
`else
  assign RX_DATA_ALIGNED = data_s1_q;
  assign RX_VALID        = valid_s1_q;
`endif

endmodule

// File: tb/tb_ddr3_rx_bitslip_align.sv
// Self-checking bench for ddr3_rx_bitslip_align: training table, corner sequences, data scoreboard.
module tb_ddr3_rx_bitslip_align;

`ifdef DDR3_RX_ALIGN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       FAB_CLK = 1'b0;
  logic       ARST;
  logic       START;
  logic [3:0] RX_DATA_0;
  logic       RX_BIT_SLIP_0;
  logic       BUSY;
  logic       LOCKED;
  logic       FAIL;
  logic [3:0] SLIP_COUNT;
  logic [3:0] RX_DATA_ALIGNED;
  logic       RX_VALID;

  always #5 FAB_CLK = ~FAB_CLK;

  ddr3_rx_bitslip_align dut (
    .FAB_CLK        (FAB_CLK),
    .ARST           (ARST),
    .START          (START),
    .RX_DATA_0      (RX_DATA_0),
    .RX_BIT_SLIP_0  (RX_BIT_SLIP_0),
    .BUSY           (BUSY),
    .LOCKED         (LOCKED),
    .FAIL           (FAIL),
    .SLIP_COUNT     (SLIP_COUNT),
    .RX_DATA_ALIGNED(RX_DATA_ALIGNED),
    .RX_VALID       (RX_VALID)
  );

  int checks = 0;
  int failures = 0;
  int cyc, pulses, min_gap, last_pulse, n;
  bit wide_pulse, slip_prev, iod_en;
  logic [3:0] sb_q[$];

  typedef struct {
    logic [3:0] word;
    int         slips;
    bit         lock;
    int         cycles;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: scoreboard the data path, watch slip pulses, model the IOD rotation.
  task automatic step();
    logic [3:0] exp_word;
    sb_q.push_back(RX_DATA_0);
    @(posedge FAB_CLK);
    #1;
    cyc++;
    if (sb_q.size() == LAT) begin
      exp_word = sb_q.pop_front();
      check("rx_data_aligned", RX_DATA_ALIGNED, exp_word);
    end
    if (RX_BIT_SLIP_0) begin
      pulses++;
      if (slip_prev) wide_pulse = 1'b1;
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      if (iod_en) RX_DATA_0 = {RX_DATA_0[0], RX_DATA_0[3:1]};
    end
    slip_prev = RX_BIT_SLIP_0;
  endtask

  task automatic clear_mon();
    cyc        = 0;
    pulses     = 0;
    min_gap    = 1000;
    last_pulse = -1;
    wide_pulse = 1'b0;
    slip_prev  = 1'b0;
  endtask

  task automatic run_train(input logic [3:0] word, input bit iod, input bit hold_start,
                           output int ncyc);
    clear_mon();
    iod_en    = iod;
    RX_DATA_0 = word;
    START     = 1'b1;
    step();
    if (!hold_start) START = 1'b0;
    check("start_busy", BUSY, 1);
    check("start_slip_count", SLIP_COUNT, 0);
    while (!(LOCKED || FAIL) && cyc < 400) step();
    check("train_done", int'(LOCKED || FAIL), 1);
    ncyc = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slip"}, RX_BIT_SLIP_0, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_locked"}, LOCKED, 0);
    check({tag, "_fail"}, FAIL, 0);
    check({tag, "_slip_count"}, SLIP_COUNT, 0);
    check({tag, "_aligned"}, RX_DATA_ALIGNED, 0);
    check({tag, "_valid"}, RX_VALID, 0);
  endtask

  initial begin
    // Lock at 1 + 4 + 16 = 21 cycles; each slip costs mismatch + slip + 4 settle = 6 more.
    vecs[0] = '{word: 4'b0011, slips: 0, lock: 1'b1, cycles: 21};
    vecs[1] = '{word: 4'b1001, slips: 3, lock: 1'b1, cycles: 39};
    vecs[2] = '{word: 4'b0110, slips: 1, lock: 1'b1, cycles: 27};
    vecs[3] = '{word: 4'b1100, slips: 2, lock: 1'b1, cycles: 33};
    vecs[4] = '{word: 4'b1111, slips: 8, lock: 1'b0, cycles: 54};
    vecs[5] = '{word: 4'b0000, slips: 8, lock: 1'b0, cycles: 54};

    ARST      = 1'b1;
    START     = 1'b0;
    RX_DATA_0 = 4'b0000;
    iod_en    = 1'b0;
    clear_mon();
    repeat (2) @(posedge FAB_CLK);
    #1;
    check_reset_outputs("reset");
    #2 ARST = 1'b0;

    foreach (vecs[i]) begin
      run_train(vecs[i].word, 1'b1, 1'b0, n);
      check($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
      check($sformatf("v%0d_locked", i), LOCKED, int'(vecs[i].lock));
      check($sformatf("v%0d_fail", i), FAIL, int'(!vecs[i].lock));
      check($sformatf("v%0d_busy", i), BUSY, 0);
      check($sformatf("v%0d_slip_count", i), SLIP_COUNT, vecs[i].slips);
      check($sformatf("v%0d_pulses", i), pulses, vecs[i].slips);
      check($sformatf("v%0d_wide_pulse", i), wide_pulse, 0);
      if (vecs[i].slips >= 2) check($sformatf("v%0d_gap_ok", i), int'(min_gap >= 5), 1);
      if (vecs[i].lock) begin
        check($sformatf("v%0d_valid_early", i), RX_VALID, 0);
        repeat (LAT) step();
        check($sformatf("v%0d_valid", i), RX_VALID, 1);
      end else begin
        check($sformatf("v%0d_valid_fail", i), RX_VALID, 0);
      end
    end

    // 15 good words, one corrupt word, then clean data: one slip, then 16 fresh matches.
    clear_mon();
    iod_en    = 1'b0;
    RX_DATA_0 = 4'b0011;
    START     = 1'b1;
    step();
    START = 1'b0;
    while (cyc < 20) step();
    check("glitch_not_locked", LOCKED, 0);
    RX_DATA_0 = 4'b0111;
    step();
    RX_DATA_0 = 4'b0011;
    check("glitch_slip_now", RX_BIT_SLIP_0, 1);
    while (!LOCKED && cyc < 400) step();
    check("glitch_lock_cycle", cyc, 42);
    check("glitch_pulses", pulses, 1);
    check("glitch_slip_count", SLIP_COUNT, 1);

    // Restart from LOCK; START pulses during FLUSH and CHECK must not disturb the run.
    clear_mon();
    START = 1'b1;
    step();
    START = 1'b0;
    while (!LOCKED && cyc < 400) begin
      START = (cyc == 3 || cyc == 10);
      step();
    end
    START = 1'b0;
    check("busy_start_lock_cycle", cyc, 21);
    check("busy_start_slip_count", SLIP_COUNT, 0);

    RX_DATA_0 = 4'hA;
    step();
    RX_DATA_0 = 4'h5;
    repeat (LAT - 1) step();
    check("latency_a", RX_DATA_ALIGNED, 4'hA);
    step();
    check("latency_5", RX_DATA_ALIGNED, 4'h5);
    check("latency_valid", RX_VALID, 1);

    // Reset during the CHECK that follows the third slip.
    clear_mon();
    iod_en    = 1'b1;
    RX_DATA_0 = 4'b1111;
    START     = 1'b1;
    step();
    START = 1'b0;
    while (pulses < 3 && cyc < 200) step();
    check("reach_slip3", pulses, 3);
    repeat (5) step();
    check("pre_reset_busy", BUSY, 1);
    check("pre_reset_slip_count", SLIP_COUNT, 3);
    #1 ARST = 1'b1;
    #1;
    check_reset_outputs("midrun");
    sb_q.delete();
    #1 ARST = 1'b0;
    step();
    check("post_reset_slip", RX_BIT_SLIP_0, 0);
    check("post_reset_busy", BUSY, 0);
    run_train(4'b0011, 1'b0, 1'b0, n);
    check("post_reset_lock_cycle", n, 21);
    check("post_reset_slip_count", SLIP_COUNT, 0);
    check("post_reset_pulses", pulses, 0);

    // START held high: lock, then training restarts on the very next cycle.
    run_train(4'b0011, 1'b0, 1'b1, n);
    check("held_lock_cycle", n, 21);
    step();
    START = 1'b0;
    check("held_relock_locked", LOCKED, 0);
    check("held_relock_busy", BUSY, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
